// File: rtl/alarm_mode_fsm_if.sv
// Keypad/button inputs and control outputs of the alarm clock mode controller.
// The FSM uses the slave view; whatever drives the keypad uses the master view.
interface alarm_mode_fsm_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       fast_button;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;
    logic       reset_count;
    logic       show_new_time;
    logic       show_a;
    logic       fast_watch;

    modport master (
        output one_second, key, alarm_button, time_button, fast_button,
        input  shift, load_new_a, load_new_c, reset_count, show_new_time, show_a, fast_watch
    );

    modport slave (
        input  one_second, key, alarm_button, time_button, fast_button,
        output shift, load_new_a, load_new_c, reset_count, show_new_time, show_a, fast_watch
    );
endinterface

// File: rtl/alarm_mode_fsm.sv
// Keypad/mode controller: sequences digit entry, alarm/current-time loads, display
// selection and the keypad inactivity timeout. Outputs are registered (Moore).
module alarm_mode_fsm #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NOKEY       = 4'd10
) (
    input logic              clock,
    input logic              reset,
    alarm_mode_fsm_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_SEC - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAIT         = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] tmo_cnt;
    logic          in_entry;
    logic          timeout;
    logic          shift_q;
    logic          load_new_a_q;
    logic          load_new_c_q;
    logic          reset_count_q;
    logic          show_new_time_q;
    logic          show_a_q;
    logic          fast_watch_q;

    assign in_entry = (state == KEY_WAIT) || (state == KEY_ENTRY);
    assign timeout  = in_entry && (tmo_cnt == TMO_LAST) && bus.one_second;

    // Priority inside each state: timeout, alarm_button, time_button, new key.
    always_comb begin
        next_state = SHOW_TIME;
        case (state)
            SHOW_TIME: begin
                if (bus.alarm_button)      next_state = SHOW_ALARM;
                else if (bus.key != NOKEY) next_state = KEY_STORED;
                else                       next_state = SHOW_TIME;
            end
            KEY_STORED: next_state = KEY_WAIT;
            KEY_WAIT: begin
                if (timeout)               next_state = SHOW_TIME;
                else if (bus.key == NOKEY) next_state = KEY_ENTRY;
                else                       next_state = KEY_WAIT;
            end
            KEY_ENTRY: begin
                if (timeout)               next_state = SHOW_TIME;
                else if (bus.alarm_button) next_state = SET_ALARM_TIME;
                else if (bus.time_button)  next_state = SET_CURRENT_TIME;
                else if (bus.key != NOKEY) next_state = KEY_STORED;
                else                       next_state = KEY_ENTRY;
            end
            SHOW_ALARM:       next_state = bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
            SET_ALARM_TIME:   next_state = SHOW_TIME;
            SET_CURRENT_TIME: next_state = SHOW_TIME;
            default:          next_state = SHOW_TIME;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= SHOW_TIME;
            tmo_cnt         <= '0;
            shift_q         <= 1'b0;
            load_new_a_q    <= 1'b0;
            load_new_c_q    <= 1'b0;
            reset_count_q   <= 1'b0;
            show_new_time_q <= 1'b0;
            show_a_q        <= 1'b0;
            fast_watch_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (!in_entry)
                tmo_cnt <= '0;
            else if (bus.one_second && (tmo_cnt != TMO_MAX))
                tmo_cnt <= tmo_cnt + TW'(1);
            shift_q         <= (next_state == KEY_STORED);
            load_new_a_q    <= (next_state == SET_ALARM_TIME);
            load_new_c_q    <= (next_state == SET_CURRENT_TIME);
            reset_count_q   <= (next_state == SET_CURRENT_TIME);
            show_new_time_q <= (next_state == KEY_STORED) || (next_state == KEY_WAIT) ||
                               (next_state == KEY_ENTRY);
            show_a_q        <= (next_state == SHOW_ALARM);
            fast_watch_q    <= bus.fast_button && (next_state == SHOW_TIME);
        end
    end

    assign bus.shift         = shift_q;
    assign bus.load_new_a    = load_new_a_q;
    assign bus.load_new_c    = load_new_c_q;
    assign bus.reset_count   = reset_count_q;
    assign bus.show_new_time = show_new_time_q;
    assign bus.show_a        = show_a_q;
    assign bus.fast_watch    = fast_watch_q;
endmodule
